// File: rtl/adpll_tx_mod.sv
// rtl/adpll_tx_mod.sv - transmit modulation sequencer feeding the ADPLL data_mod input
// Frames a byte stream as preamble, LSB-first payload and tail bits, one bit every BIT_DIV clocks.
module adpll_tx_mod #(
  parameter int BIT_DIV      = 32,
  parameter int PREAMBLE_LEN = 8,
  parameter int TAIL_BITS    = 2,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] adpll_mode,
  input  logic       channel_lock,
  input  logic       tx_start,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data_mod,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [1:0]  MODE_TX   = 2'd3;
  localparam logic [7:0]  BIT_LAST  = 8'(BIT_DIV - 1);
  localparam logic [6:0]  PRE_BITS  = 7'(PREAMBLE_LEN);
  localparam logic [6:0]  TAIL_N    = 7'(TAIL_BITS);
  localparam logic [11:0] LOCK_LAST = 12'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_PREAMBLE, S_DATA, S_TAIL, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  bits_left, bits_left_n;
  logic [11:0] lock_cnt, lock_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        shift_last, shift_last_n;
  logic [7:0]  buf_data, buf_data_n;
  logic        buf_last, buf_last_n;
  logic        buf_full, buf_full_n;
  logic        last_acc, last_acc_n;
  logic        data_mod_q, data_mod_n;
  logic        tx_err_q, tx_err_n;
  logic        boundary, last_bit, xfer, abort, framing;

  assign framing    = (state == S_PREAMBLE) || (state == S_DATA) || (state == S_TAIL);
  assign boundary   = (bit_cnt == BIT_LAST);
  assign last_bit   = (bits_left == 7'd1);
  assign byte_ready = en && !buf_full && !last_acc && ((state == S_PREAMBLE) || (state == S_DATA));
  assign xfer       = byte_valid && byte_ready;
  assign data_mod   = data_mod_q;
  assign busy       = (state != S_IDLE);
  assign tx_done    = (state == S_DONE);
  assign tx_err     = tx_err_q;

  always_comb begin
    abort = 1'b0;
    if (state != S_IDLE && adpll_mode != MODE_TX)
      abort = 1'b1;
    if (framing && !channel_lock)
      abort = 1'b1;
    if (state == S_WAIT_LOCK && !channel_lock && lock_cnt == LOCK_LAST)
      abort = 1'b1;
    // Underrun: the next byte must already be buffered when the current bit run ends.
    if (state == S_PREAMBLE && boundary && last_bit && !buf_full)
      abort = 1'b1;
    if (state == S_DATA && boundary && last_bit && !shift_last && !buf_full)
      abort = 1'b1;
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    bits_left_n  = bits_left;
    lock_cnt_n   = lock_cnt;
    shift_n      = shift;
    shift_last_n = shift_last;
    buf_data_n   = buf_data;
    buf_last_n   = buf_last;
    buf_full_n   = buf_full;
    last_acc_n   = last_acc;
    data_mod_n   = data_mod_q;
    tx_err_n     = tx_err_q;

    if (xfer) begin
      buf_data_n = byte_data;
      buf_last_n = byte_last;
      buf_full_n = 1'b1;
      if (byte_last)
        last_acc_n = 1'b1;
    end

    if (framing)
      bit_cnt_n = boundary ? 8'd0 : bit_cnt + 8'd1;

    case (state)
      S_IDLE: begin
        data_mod_n = 1'b0;
        last_acc_n = 1'b0;
        if (tx_start && adpll_mode == MODE_TX) begin
          tx_err_n   = 1'b0;
          lock_cnt_n = 12'd0;
          state_n    = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        data_mod_n = 1'b0;
        lock_cnt_n = lock_cnt + 12'd1;
        if (channel_lock) begin
          bit_cnt_n   = 8'd0;
          bits_left_n = PRE_BITS;
          data_mod_n  = 1'b1;
          state_n     = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (boundary) begin
          bits_left_n = bits_left - 7'd1;
          data_mod_n  = ~data_mod_q;
          if (last_bit) begin
            shift_n      = buf_data;
            shift_last_n = buf_last;
            buf_full_n   = xfer;
            bits_left_n  = 7'd8;
            data_mod_n   = buf_data[0];
            state_n      = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (boundary) begin
          bits_left_n = bits_left - 7'd1;
          shift_n     = {1'b0, shift[7:1]};
          data_mod_n  = shift[1];
          if (last_bit) begin
            if (shift_last) begin
              data_mod_n  = 1'b0;
              bits_left_n = TAIL_N;
              state_n     = (TAIL_BITS == 0) ? S_DONE : S_TAIL;
            end else begin
              // Reload uses the old buffer; a same-edge transfer refills it.
              shift_n      = buf_data;
              shift_last_n = buf_last;
              buf_full_n   = xfer;
              bits_left_n  = 7'd8;
              data_mod_n   = buf_data[0];
            end
          end
        end
      end
      S_TAIL: begin
        data_mod_n = 1'b0;
        if (boundary) begin
          bits_left_n = bits_left - 7'd1;
          if (last_bit)
            state_n = S_DONE;
        end
      end
      S_DONE: begin
        data_mod_n = 1'b0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n     = S_IDLE;
      tx_err_n    = 1'b1;
      data_mod_n  = 1'b0;
      buf_full_n  = 1'b0;
      last_acc_n  = 1'b0;
      bit_cnt_n   = 8'd0;
      bits_left_n = 7'd0;
      lock_cnt_n  = 12'd0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 8'd0;
      bits_left  <= 7'd0;
      lock_cnt   <= 12'd0;
      shift      <= 8'd0;
      shift_last <= 1'b0;
      buf_data   <= 8'd0;
      buf_last   <= 1'b0;
      buf_full   <= 1'b0;
      last_acc   <= 1'b0;
      data_mod_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else if (en) begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      bits_left  <= bits_left_n;
      lock_cnt   <= lock_cnt_n;
      shift      <= shift_n;
      shift_last <= shift_last_n;
      buf_data   <= buf_data_n;
      buf_last   <= buf_last_n;
      buf_full   <= buf_full_n;
      last_acc   <= last_acc_n;
      data_mod_q <= data_mod_n;
      tx_err_q   <= tx_err_n;
    end
  end

endmodule

// File: tb/tb_adpll_tx_mod.sv
// tb/tb_adpll_tx_mod.sv - directed bench for adpll_tx_mod with a per-cycle expected-output queue
module tb_adpll_tx_mod;

  localparam int BD   = 4;
  localparam int PRE  = 8;
  localparam int TAIL = 2;
  localparam int LTO  = 16;

  logic       clk = 1'b0;
  logic       rst, en, channel_lock, tx_start;
  logic [1:0] adpll_mode;
  logic [7:0] byte_data;
  logic       byte_last, byte_valid;
  logic       byte_ready, data_mod, busy, tx_done, tx_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic dm; logic busy; logic done; logic err;} exp_t;
  exp_t       exp_q[$];
  bit         frame_bits[$];
  logic [8:0] tx_q[$];

  adpll_tx_mod #(.BIT_DIV(BD), .PREAMBLE_LEN(PRE), .TAIL_BITS(TAIL), .LOCK_TIMEOUT(LTO)) dut (
    .clk(clk), .rst(rst), .en(en), .adpll_mode(adpll_mode), .channel_lock(channel_lock),
    .tx_start(tx_start), .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .data_mod(data_mod), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit dm, input bit b, input bit d, input bit e);
    exp_t r;
    r.dm = dm; r.busy = b; r.done = d; r.err = e;
    return r;
  endfunction

  // Outputs settle after the falling edge; the rising edge is a quiet sampling point.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data_mod", 32'(data_mod), 32'(e.dm));
      chk("busy",     32'(busy),     32'(e.busy));
      chk("tx_done",  32'(tx_done),  32'(e.done));
      chk("tx_err",   32'(tx_err),   32'(e.err));
    end
  end

  // Byte source: presents the queue head, pops it when a transfer will happen on the next fall.
  initial begin
    byte_valid = 1'b0; byte_data = 8'd0; byte_last = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (tx_q.size() > 0) begin
        byte_valid = 1'b1; byte_data = tx_q[0][7:0]; byte_last = tx_q[0][8];
      end else begin
        byte_valid = 1'b0;
      end
      #2;
      if (byte_valid && byte_ready && !rst) tx_q.delete(0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic make_bits(input logic [7:0] b0, input logic [7:0] b1, input int nb);
    frame_bits.delete();
    for (int i = 0; i < PRE; i++) frame_bits.push_back(i % 2 == 0);
    for (int j = 0; j < nb; j++)
      for (int i = 0; i < 8; i++) frame_bits.push_back(j == 0 ? b0[i] : b1[i]);
    for (int i = 0; i < TAIL; i++) frame_bits.push_back(1'b0);
  endtask

  function automatic logic [31:0] pack(input int lo, input int n);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r[i] = frame_bits[lo + i];
    return r;
  endfunction

  // One WAIT_LOCK cycle, then frame cycles t=0..stop_t (all of them when stop_t<0).
  task automatic expect_frame(input int stop_t, input bit end_err);
    int n, last;
    exp_q.push_back(mk(0, 1, 0, 0));
    n = frame_bits.size() * BD;
    last = (stop_t < 0) ? n - 1 : stop_t;
    for (int t = 0; t <= last; t++) exp_q.push_back(mk(frame_bits[t / BD], 1, 0, 0));
    if (stop_t < 0) begin
      exp_q.push_back(mk(0, 1, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0));
    end else begin
      exp_q.push_back(mk(0, 0, 0, end_err));
    end
  endtask

  task automatic start_frame();
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tick();
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() > 0 && i < 3000) begin tick(); i++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    exp_t e;
    rst = 1'b1; en = 1'b1; adpll_mode = 2'd3; channel_lock = 1'b1; tx_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_data_mod", 32'(data_mod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    tick();

    // tx_start outside TX mode is ignored
    adpll_mode = 2'd2; tx_start = 1'b1; tick(); tx_start = 1'b0; adpll_mode = 2'd3; tick();
    chk("start_ignored_busy", 32'(busy), 32'd0);

    // normal frame, single byte 0xA5
    tx_q.push_back({1'b1, 8'hA5});
    make_bits(8'hA5, 8'h00, 1);
    chk("model_len", 32'(frame_bits.size()), 32'd18);
    chk("model_preamble", pack(0, 8), 32'h55);
    chk("model_a5", pack(8, 8), 32'hA5);
    expect_frame(-1, 1'b0);
    chk("model_cycles", 32'(exp_q.size()), 32'd75);
    start_frame();
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("done_latency", 32'(n), 32'd72);
    drain();

    // two bytes back to back
    tx_q.push_back({1'b0, 8'h0F});
    tx_q.push_back({1'b1, 8'hF0});
    make_bits(8'h0F, 8'hF0, 2);
    chk("model_two_bytes", pack(8, 16), 32'hF00F);
    expect_frame(-1, 1'b0);
    start_frame();
    repeat (63) tick();
    chk("second_byte_taken", 32'(tx_q.size()), 32'd0);
    drain();

    // lock timeout
    channel_lock = 1'b0;
    for (int i = 0; i < LTO; i++) exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    tx_start = 1'b1; tick(); tx_start = 1'b0;
    drain();
    channel_lock = 1'b1;

    // underrun after a non-last byte
    tx_q.push_back({1'b0, 8'h00});
    make_bits(8'h00, 8'h00, 1);
    expect_frame(63, 1'b1);
    start_frame();
    drain();

    // mode change in DATA
    tx_q.push_back({1'b1, 8'h3C});
    make_bits(8'h3C, 8'h00, 1);
    expect_frame(40, 1'b1);
    start_frame();
    repeat (40) tick();
    adpll_mode = 2'd2; tick(); adpll_mode = 2'd3;
    drain();

    // one-cycle loss of lock
    tx_q.push_back({1'b1, 8'h81});
    make_bits(8'h81, 8'h00, 1);
    expect_frame(20, 1'b1);
    start_frame();
    repeat (20) tick();
    channel_lock = 1'b0; tick(); channel_lock = 1'b1;
    drain();

    // reset in DATA, then a fresh frame
    tx_q.push_back({1'b1, 8'hC3});
    make_bits(8'hC3, 8'h00, 1);
    expect_frame(45, 1'b0);
    start_frame();
    repeat (45) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_byte_ready", 32'(byte_ready), 32'd0);
    drain();
    tx_q.push_back({1'b1, 8'hA5});
    make_bits(8'hA5, 8'h00, 1);
    expect_frame(-1, 1'b0);
    start_frame();
    drain();

    // en low for 5 cycles in the middle of preamble bit 2
    tx_q.push_back({1'b1, 8'h5A});
    make_bits(8'h5A, 8'h00, 1);
    expect_frame(-1, 1'b0);
    e = exp_q[11];
    for (int i = 0; i < 5; i++) exp_q.insert(11, e);
    start_frame();
    repeat (10) tick();
    en = 1'b0; repeat (5) tick(); en = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
